// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: FSM states, access sizes,
// byte-enable codes and vector geometry.
package lsu_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_CAPT   = 3'd2;
   localparam logic [2:0] S_RMW_WR = 3'd3;
   localparam logic [2:0] S_RESP   = 3'd4;
   localparam logic [2:0] S_ERR    = 3'd5;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam logic [1:0] BE_BYTE = 2'b00;
   localparam logic [1:0] BE_HALF = 2'b01;
   localparam logic [1:0] BE_WORD = 2'b11;

   localparam int VEC_LANES = 4;
   localparam int VEC_W     = 128;

   typedef logic [VEC_LANES-1:0][VEC_W-1:0] vec_data_t;

   function automatic logic [1:0] size_to_be(input logic [1:0] size);
      case (size)
         SZ_B:    return BE_BYTE;
         SZ_H:    return BE_HALF;
         default: return BE_WORD;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath helpers: fault detection on the incoming request,
// load lane extraction with sign/zero extension, and store lane merge.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int MEM_LINES = 1024,
   parameter int ADDR_W    = 32
)
(
   input  logic              chk_vec,
   input  logic [1:0]        chk_size,
   input  logic [ADDR_W-1:0] chk_addr,
   output logic              fault,
   input  logic [1:0]        size,
   input  logic              zext,
   input  logic [1:0]        off,
   input  logic [31:0]       rd_word,
   input  logic [31:0]       wdata,
   output logic [31:0]       load_data,
   output logic [31:0]       merge_data
);

   logic [ADDR_W:0] last_line;
   logic [7:0]      sel_b;
   logic [15:0]     sel_h;

   // Vector accesses span four consecutive lines; one extra bit keeps the sum from wrapping.
   always_comb begin
      last_line = {{5{1'b0}}, chk_addr[ADDR_W-1:4]} + (ADDR_W+1)'(3);
      fault     = 1'b0;
      if (chk_vec) begin
         fault = (chk_addr[3:0] != 4'd0) || (last_line >= (ADDR_W+1)'(MEM_LINES));
      end else begin
         case (chk_size)
            SZ_B:    fault = 1'b0;
            SZ_H:    fault = chk_addr[0];
            SZ_W:    fault = |chk_addr[1:0];
            default: fault = 1'b1;
         endcase
      end
   end

   always_comb begin
      sel_b = rd_word[{off, 3'b000} +: 8];
      sel_h = off[1] ? rd_word[31:16] : rd_word[15:0];
      case (size)
         SZ_B:    load_data = zext ? {24'd0, sel_b} : {{24{sel_b[7]}}, sel_b};
         SZ_H:    load_data = zext ? {16'd0, sel_h} : {{16{sel_h[15]}}, sel_h};
         default: load_data = rd_word;
      endcase
   end

   always_comb begin
      merge_data = rd_word;
      if (size == SZ_B) begin
         merge_data[{off, 3'b000} +: 8] = wdata[7:0];
      end else if (size == SZ_H) begin
         if (off[1]) merge_data[31:16] = wdata[15:0];
         else        merge_data[15:0]  = wdata[15:0];
      end
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of the data memory: one request at a time,
// alignment/bounds checks, read-modify-write for offset sub-word stores.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int MEM_LINES = 1024,
   parameter int ADDR_W    = 32
)
(
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                lsu_req_valid,
   output logic                                lsu_req_ready,
   input  logic                                lsu_req_wr,
   input  logic                                lsu_req_vec,
   input  logic [1:0]                          lsu_req_size,
   input  logic                                lsu_req_unsigned,
   input  logic [ADDR_W-1:0]                   lsu_req_addr,
   input  logic [31:0]                         lsu_req_wdata,
   input  logic [VEC_LANES-1:0][VEC_W-1:0]     lsu_req_vwdata,
   output logic                                lsu_resp_valid,
   output logic                                lsu_resp_err,
   output logic [31:0]                         lsu_resp_rdata,
   output logic [VEC_LANES-1:0][VEC_W-1:0]     lsu_resp_vrdata,
   output logic                                data_mem_req,
   output logic                                data_mem_wr,
   output logic [ADDR_W-1:0]                   data_mem_addr,
   output logic [31:0]                         data_mem_wr_data,
   output logic [1:0]                          data_mem_byte_en,
   output logic                                is_vector_o,
   output logic [VEC_LANES-1:0][VEC_W-1:0]     vec_data_wr_data_o,
   input  logic [31:0]                         mem_rd_data,
   input  logic [VEC_LANES-1:0][VEC_W-1:0]     vec_mem_rd_data_i
);

   // Handshake: a request transfers on a rising edge where lsu_req_valid && lsu_req_ready;
   // ready is high only in IDLE, and the response is a one-cycle pulse with no backpressure.
   logic [2:0]        state;
   logic              wr_q, vec_q, uns_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, word_q;
   vec_data_t         vwdata_q, vrdata_q;

   logic              fault, sub_store, issue_wr;
   logic [31:0]       load_data, merge_data, store_word;

   lsu_align #(.MEM_LINES(MEM_LINES), .ADDR_W(ADDR_W)) u_align (
      .chk_vec    (lsu_req_vec),
      .chk_size   (lsu_req_size),
      .chk_addr   (lsu_req_addr),
      .fault      (fault),
      .size       (size_q),
      .zext       (uns_q),
      .off        (addr_q[1:0]),
      .rd_word    (mem_rd_data),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   assign sub_store = wr_q && !vec_q && (size_q != SZ_W) && (addr_q[1:0] != 2'b00);
   assign issue_wr  = wr_q && !sub_store;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         wr_q     <= 1'b0;
         vec_q    <= 1'b0;
         uns_q    <= 1'b0;
         size_q   <= 2'b00;
         addr_q   <= '0;
         wdata_q  <= '0;
         word_q   <= '0;
         vwdata_q <= '0;
         vrdata_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (lsu_req_valid) begin
                  wr_q     <= lsu_req_wr;
                  vec_q    <= lsu_req_vec;
                  uns_q    <= lsu_req_unsigned;
                  size_q   <= lsu_req_size;
                  addr_q   <= lsu_req_addr;
                  wdata_q  <= lsu_req_wdata;
                  vwdata_q <= lsu_req_vwdata;
                  word_q   <= '0;
                  vrdata_q <= '0;
                  state    <= fault ? S_ERR : S_ISSUE;
               end
            end
            S_ISSUE: state <= issue_wr ? S_RESP : S_CAPT;
            S_CAPT: begin
               // Only a sub-word store reaches CAPT with wr set, so word_q holds the merged word.
               word_q <= wr_q ? merge_data : load_data;
               if (vec_q && !wr_q) vrdata_q <= vec_mem_rd_data_i;
               state <= wr_q ? S_RMW_WR : S_RESP;
            end
            S_RMW_WR: state <= S_RESP;
            default:  state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      case (size_q)
         SZ_B:    store_word = {24'd0, wdata_q[7:0]};
         SZ_H:    store_word = {16'd0, wdata_q[15:0]};
         default: store_word = wdata_q;
      endcase
   end

   always_comb begin
      lsu_req_ready      = (state == S_IDLE);
      lsu_resp_valid     = (state == S_RESP) || (state == S_ERR);
      lsu_resp_err       = (state == S_ERR);
      lsu_resp_rdata     = (state == S_RESP && !wr_q && !vec_q) ? word_q : 32'd0;
      lsu_resp_vrdata    = (state == S_RESP && !wr_q && vec_q) ? vrdata_q : '0;
      data_mem_req       = 1'b0;
      data_mem_wr        = 1'b0;
      data_mem_addr      = '0;
      data_mem_wr_data   = 32'd0;
      data_mem_byte_en   = 2'b00;
      is_vector_o        = 1'b0;
      vec_data_wr_data_o = '0;
      if (state == S_ISSUE) begin
         data_mem_req     = 1'b1;
         data_mem_wr      = issue_wr;
         data_mem_addr    = {addr_q[ADDR_W-1:2], 2'b00};
         is_vector_o      = vec_q;
         data_mem_byte_en = (issue_wr && !vec_q) ? size_to_be(size_q) : BE_WORD;
         if (issue_wr && vec_q)  vec_data_wr_data_o = vwdata_q;
         if (issue_wr && !vec_q) data_mem_wr_data   = store_word;
      end else if (state == S_RMW_WR) begin
         data_mem_req     = 1'b1;
         data_mem_wr      = 1'b1;
         data_mem_addr    = {addr_q[ADDR_W-1:2], 2'b00};
         data_mem_wr_data = word_q;
         data_mem_byte_en = BE_WORD;
      end
   end

endmodule
